// File: rtl/led_pattern_gen.sv
// Purpose : multi-channel LED pattern generator (off / on / blink / PWM) from one shared half-period timebase.
// Latency : led is registered, one cycle behind internal state; new config lands on the first wrap after capture.
// Backpressure: cfg_ready drops on capture and returns the cycle after the config is applied.
//
// Ports:
//   FAB_CLK    - sole clock, rising edge
//   FAB_LOCK   - asynchronous active-low reset (fabric PLL lock)
//   cfg_valid/cfg_ready - configuration handshake
//   cfg_mode   - 2 bits per channel: 00 off, 01 on, 10 blink, 11 PWM
//   cfg_phase  - per-channel blink inversion
//   cfg_duty   - PWM_W bits per channel (used only when LED_PWM_EN is defined)
//   cfg_half   - new half-period in clocks, 0 selects HALF_PERIOD
//   led        - registered LED drive
//   tick       - one-cycle pulse at every half-period boundary
//
// Build option: define LED_PWM_EN to build the PWM engine; otherwise mode 11 drives the LED on.

module led_pattern_gen #(
  parameter int N_LEDS      = 4,
  parameter int CNT_W       = 32,
  parameter int HALF_PERIOD = 20000000,
  parameter int PWM_W       = 8
) (
  input  logic                    FAB_CLK,
  input  logic                    FAB_LOCK,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [2*N_LEDS-1:0]     cfg_mode,
  input  logic [N_LEDS-1:0]       cfg_phase,
  input  logic [PWM_W*N_LEDS-1:0] cfg_duty,
  input  logic [CNT_W-1:0]        cfg_half,
  output logic [N_LEDS-1:0]       led,
  output logic                    tick
);

  localparam logic [CNT_W-1:0] HALF_DEF = CNT_W'(HALF_PERIOD);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } cfg_state_t;

  cfg_state_t state, state_nxt;

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    act_half, pend_half;
  logic [2*N_LEDS-1:0] act_mode, pend_mode;
  logic [N_LEDS-1:0]   act_phase, pend_phase;
  logic [N_LEDS-1:0]   led_nxt;
  logic                blink_ph;
  logic                wrap;
  logic                xfer;
  logic                apply;

`ifdef LED_PWM_EN
  logic [PWM_W*N_LEDS-1:0] act_duty, pend_duty;
  logic [PWM_W-1:0]        pwm_cnt;
`else
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
`endif

  // act_half is never 0, so half-1 cannot underflow.
  assign wrap  = (cnt == act_half - CNT_W'(1));
  assign xfer  = cfg_valid && cfg_ready;
  // Only a config already pending before this cycle may apply, so a
  // capture that lands on a wrap waits for the following wrap.
  assign apply = wrap && (state == ST_PEND);

  always_ff @(posedge FAB_CLK or negedge FAB_LOCK) begin
    if (!FAB_LOCK) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (wrap) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      case (act_mode[2*i +: 2])
        2'b00: led_nxt[i] = 1'b0;
        2'b01: led_nxt[i] = 1'b1;
        2'b10: led_nxt[i] = blink_ph ^ act_phase[i];
`ifdef LED_PWM_EN
        2'b11: led_nxt[i] = (pwm_cnt < act_duty[PWM_W*i +: PWM_W]);
`else
        2'b11: led_nxt[i] = 1'b1;
`endif
        default: led_nxt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge FAB_CLK or negedge FAB_LOCK) begin
    if (!FAB_LOCK) begin
      cnt        <= '0;
      blink_ph   <= 1'b0;
      tick       <= 1'b0;
      led        <= '0;
      act_half   <= HALF_DEF;
      act_mode   <= '0;
      act_phase  <= '0;
      pend_half  <= HALF_DEF;
      pend_mode  <= '0;
      pend_phase <= '0;
`ifdef LED_PWM_EN
      act_duty   <= '0;
      pend_duty  <= '0;
      pwm_cnt    <= '0;
`endif
    end else begin
      cnt  <= wrap ? '0 : cnt + CNT_W'(1);
      tick <= wrap;
      led  <= led_nxt;
      if (wrap) blink_ph <= ~blink_ph;
`ifdef LED_PWM_EN
      pwm_cnt <= pwm_cnt + PWM_W'(1);
`endif
      if (xfer) begin
        pend_mode  <= cfg_mode;
        pend_phase <= cfg_phase;
        pend_half  <= (cfg_half == '0) ? HALF_DEF : cfg_half;
`ifdef LED_PWM_EN
        pend_duty  <= cfg_duty;
`endif
      end
      // Apply always coincides with a wrap, so cnt is already being cleared.
      if (apply) begin
        act_mode  <= pend_mode;
        act_phase <= pend_phase;
        act_half  <= pend_half;
`ifdef LED_PWM_EN
        act_duty  <= pend_duty;
`endif
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Purpose : directed self-checking bench for led_pattern_gen (HALF_PERIOD shrunk to 6).
// Latency : checks sample #1 after each rising edge; inputs change at the same point.
// Backpressure: exercises capture, held cfg_valid while not ready, and ready return after apply.

module tb_led_pattern_gen;

  logic        FAB_CLK = 1'b0;
  logic        FAB_LOCK = 1'b0;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_mode;
  logic [3:0]  cfg_phase;
  logic [31:0] cfg_duty;
  logic [31:0] cfg_half;
  logic [3:0]  led;
  logic        tick;

  int n_pass  = 0;
  int n_total = 0;

`ifdef LED_PWM_EN
  localparam logic [3:0] MIX_A = 4'b0010;
  localparam logic [3:0] MIX_B = 4'b0001;
  localparam int EXP_CNT [4] = '{0, 64, 255, 128};
`else
  localparam logic [3:0] MIX_A = 4'b0110;
  localparam logic [3:0] MIX_B = 4'b0101;
  localparam int EXP_CNT [4] = '{256, 256, 256, 256};
`endif

  led_pattern_gen #(
    .N_LEDS(4), .CNT_W(32), .HALF_PERIOD(6), .PWM_W(8)
  ) dut (
    .FAB_CLK(FAB_CLK), .FAB_LOCK(FAB_LOCK),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_phase(cfg_phase),
    .cfg_duty(cfg_duty), .cfg_half(cfg_half),
    .led(led), .tick(tick)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  task automatic step(input int n = 1);
    repeat (n) @(posedge FAB_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic offer(input logic [7:0] m, input logic [3:0] p,
                       input logic [31:0] d, input logic [31:0] h);
    cfg_mode  = m;
    cfg_phase = p;
    cfg_duty  = d;
    cfg_half  = h;
    cfg_valid = 1'b1;
  endtask

  initial begin
    int ones [4];
    cfg_valid = 1'b0;
    cfg_mode  = '0;
    cfg_phase = '0;
    cfg_duty  = '0;
    cfg_half  = '0;
    #1;
    chk("rst_led", led, 0);
    chk("rst_tick", tick, 0);
    chk("rst_rdy", cfg_ready, 1);

    // Release, then load half=4 all-blink phase 0101 right after edge 1.
    step(2);
    FAB_LOCK = 1'b1;
    step(1);
    offer(8'hAA, 4'b0101, 32'h0, 32'd4);
    step(1);
    cfg_valid = 1'b0;
    chk("cap_rdy", cfg_ready, 0);
    step(3);
    chk("pre_wrap_tick", tick, 0);
    step(1);                              // edge 6: first wrap applies the config
    chk("apply_tick", tick, 1);
    chk("apply_rdy", cfg_ready, 1);
    chk("apply_led", led, 0);
    for (int j = 1; j <= 11; j++) begin
      step(1);
      chk("blink4_tick", tick, (j % 4 == 0) ? 1 : 0);
      chk("blink4_led", led, (((j - 1) / 4) % 2 == 0) ? 4'b1010 : 4'b0101);
    end

    // Now on a wrap cycle (cnt==3): handshake coincides with wrap, switch to half=8.
    offer(8'hAA, 4'b0101, 32'h0, 32'd8);
    step(1);
    cfg_valid = 1'b0;
    chk("wrapcap_rdy", cfg_ready, 0);
    chk("wrapcap_tick", tick, 1);
    step(3);
    chk("wait4_rdy", cfg_ready, 0);
    chk("wait4_tick", tick, 0);
    step(1);
    chk("h8_apply_rdy", cfg_ready, 1);
    chk("h8_apply_tick", tick, 1);
    step(7);
    chk("h8_pre_tick", tick, 0);

    // Handshake on the wrap with half=8 active; later offers are ignored.
    offer(8'h55, 4'b0000, 32'h0, 32'd8);
    step(1);
    chk("h8cap_rdy", cfg_ready, 0);
    chk("h8cap_tick", tick, 1);
    cfg_mode = 8'h00;
    cfg_half = 32'd1;
    step(7);
    chk("h8wait_rdy", cfg_ready, 0);
    chk("h8wait_tick", tick, 0);
    chk("h8wait_led", led, 4'b0101);
    cfg_valid = 1'b0;
    step(1);
    chk("on_apply_tick", tick, 1);
    chk("on_apply_rdy", cfg_ready, 1);
    chk("on_apply_led", led, 4'b0101);
    step(1);
    chk("on_led", led, 4'b1111);

    // half=1, ch0 blink, ch1 blink inverted, ch2 mode 11 duty 0, ch3 off.
    offer(8'h3A, 4'b0010, 32'hAB00_CDEF, 32'd1);
    step(1);
    cfg_valid = 1'b0;
    chk("h1cap_rdy", cfg_ready, 0);
    step(5);
    chk("h1wait_rdy", cfg_ready, 0);
    chk("h1wait_led", led, 4'b1111);
    step(1);
    chk("h1apply_tick", tick, 1);
    step(1);
    chk("h1_rdy", cfg_ready, 1);
    chk("h1_tick_a", tick, 1);
    chk("h1_led_a", led, MIX_A);
    step(1);
    chk("h1_tick_b", tick, 1);
    chk("h1_led_b", led, MIX_B);
    step(1);
    chk("h1_led_c", led, MIX_A);

    // All mode 11, duties 0/64/255/128; count highs over 256 cycles.
    offer(8'hFF, 4'b0000, 32'h80FF_4000, 32'd1);
    step(1);
    cfg_valid = 1'b0;
    step(3);
    for (int c = 0; c < 4; c++) ones[c] = 0;
    for (int k = 0; k < 256; k++) begin
      step(1);
      for (int c = 0; c < 4; c++) ones[c] += int'(led[c]);
    end
    for (int c = 0; c < 4; c++) chk($sformatf("pwm_cnt_ch%0d", c), ones[c], EXP_CNT[c]);

    // cfg_half=0 selects HALF_PERIOD (6).
    offer(8'hAA, 4'b0101, 32'h0, 32'd0);
    step(1);
    cfg_valid = 1'b0;
    step(1);
    chk("h0apply_tick", tick, 1);
    chk("h0apply_rdy", cfg_ready, 1);
    step(5);
    chk("h0_gap_tick", tick, 0);
    offer(8'h55, 4'b0000, 32'h0, 32'd1);
    step(1);
    cfg_valid = 1'b0;
    chk("h0_tick", tick, 1);
    chk("pend_rdy", cfg_ready, 0);
    chk("pre_rst_led", ((led == 4'b0101) || (led == 4'b1010)) ? 1 : 0, 1);

    // Asynchronous reset mid-blink with a config pending.
    FAB_LOCK = 1'b0;
    #1;
    chk("arst_led", led, 0);
    chk("arst_tick", tick, 0);
    chk("arst_rdy", cfg_ready, 1);
    step(2);
    FAB_LOCK = 1'b1;
    step(5);
    chk("rel_pre_tick", tick, 0);
    step(1);
    chk("rel_tick", tick, 1);
    chk("rel_rdy", cfg_ready, 1);
    step(2);
    chk("rel_led_off", led, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
